// File: rtl/ram_display_controller.sv
// Sequencer/arbiter for the single-port character RAM: buffers received characters into RAM
// and streams RAM contents to the transmitter. Optional bulk clear is enabled by RAM_CTRL_CLEAR_EN.
module ram_display_controller #(
  parameter int                DEPTH      = 40,
  parameter int                ADDR_W     = 6,
  parameter int                DATA_W     = 7,
  parameter logic [DATA_W-1:0] TERMINATOR = 7'h0D
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_start,
`ifdef RAM_CTRL_CLEAR_EN
  input  logic              i_clear,
`endif
  input  logic              i_tx_ready,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_ram_write_enabled,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_busy,
  output logic              o_dump_done,
  output logic              o_overrun,
  output logic [ADDR_W-1:0] o_write_pointer,
  output logic [2:0]        o_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
`ifdef RAM_CTRL_CLEAR_EN
  localparam logic [2:0]        ST_CLEAR   = 3'd4;
  localparam logic [DATA_W-1:0] BLANK_CHAR = 7'h20;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_data;
  logic              r_dump_req;
  logic              r_dump_active;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_tx_valid;
  logic              r_dump_done;
  logic              r_overrun;
`ifdef RAM_CTRL_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;
`endif

  logic [ADDR_W-1:0] w_wp_next;
  logic              w_transfer;
  logic              w_last_char;

  assign w_wp_next   = (r_wp == LAST_ADDR) ? '0 : r_wp + 1'b1;
  assign w_transfer  = (r_state == ST_SEND) && i_tx_ready;
  assign w_last_char = (r_tx_data == TERMINATOR) || (r_rp == LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_wp          <= '0;
      r_rp          <= '0;
      r_hold_full   <= 1'b0;
      r_hold_data   <= '0;
      r_dump_req    <= 1'b0;
      r_dump_active <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_dump_done   <= 1'b0;
      r_overrun     <= 1'b0;
`ifdef RAM_CTRL_CLEAR_EN
      r_clr_addr    <= '0;
`endif
    end else begin
      r_dump_done <= 1'b0;

      // The holder is still counted as full during its own WRITE cycle.
      if (i_rx_valid) begin
        if (r_hold_full) begin
          r_overrun <= 1'b1;
        end else begin
          r_hold_data <= i_rx_data;
          r_hold_full <= 1'b1;
        end
      end

      if (i_start && !r_dump_active) begin
        r_dump_req <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
`ifdef RAM_CTRL_CLEAR_EN
          if (i_clear) begin
            r_clr_addr <= '0;
            r_state    <= ST_CLEAR;
          end else
`endif
          if (r_hold_full) begin
            r_state <= ST_WRITE;
          end else if (r_dump_req || i_start) begin
            // Start is taken directly here so the first character appears two cycles later.
            r_dump_req    <= 1'b0;
            r_dump_active <= 1'b1;
            r_rp          <= '0;
            r_state       <= ST_READ;
          end
        end

        ST_WRITE: begin
          r_wp        <= w_wp_next;
          r_hold_full <= 1'b0;
          if ((r_hold_data == TERMINATOR) && !r_dump_active) begin
            r_dump_req <= 1'b1;
          end
          r_state <= r_dump_active ? ST_READ : ST_IDLE;
        end

        ST_READ: begin
          r_tx_data  <= i_ram_dout;
          r_tx_valid <= 1'b1;
          r_state    <= ST_SEND;
        end

        ST_SEND: begin
          if (w_transfer) begin
            r_tx_valid <= 1'b0;
            if (w_last_char) begin
              r_dump_done   <= 1'b1;
              r_dump_active <= 1'b0;
              r_state       <= ST_IDLE;
            end else begin
              r_rp    <= r_rp + 1'b1;
              r_state <= r_hold_full ? ST_WRITE : ST_READ;
            end
          end
        end

`ifdef RAM_CTRL_CLEAR_EN
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST_ADDR) begin
            r_wp    <= '0;
            r_state <= ST_IDLE;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM port belongs to the read pointer except in the write-type states.
  always_comb begin
    o_ram_address       = r_rp;
    o_ram_din           = '0;
    o_ram_write_enabled = 1'b0;
    case (r_state)
      ST_WRITE: begin
        o_ram_address       = r_wp;
        o_ram_din           = r_hold_data;
        o_ram_write_enabled = 1'b1;
      end
`ifdef RAM_CTRL_CLEAR_EN
      ST_CLEAR: begin
        o_ram_address       = r_clr_addr;
        o_ram_din           = BLANK_CHAR;
        o_ram_write_enabled = 1'b1;
      end
`endif
      default: begin
        o_ram_address = r_rp;
      end
    endcase
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_dump_done     = r_dump_done;
  assign o_overrun       = r_overrun;
  assign o_write_pointer = r_wp;
  assign o_state         = r_state;

endmodule

// File: tb/tb_ram_display_controller.sv
// Directed bench for ram_display_controller with a behavioural 40x7 RAM and a transmit scoreboard.
module tb_ram_display_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       tx_ready = 1'b1;
  logic [6:0] tx_data;
  logic       tx_valid;
  logic [5:0] ram_address;
  logic [6:0] ram_din;
  logic       ram_we;
  logic [6:0] ram_dout;
  logic       busy;
  logic       dump_done;
  logic       overrun;
  logic [5:0] write_pointer;
  logic [2:0] state;

  logic [6:0] mem [0:39];
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [6:0] ld_data = '0;

  logic [6:0] exp_q[$];
  int n_total = 0;
  int n_bad = 0;
  int dd_cnt = 0;

  ram_display_controller dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_rx_data           (rx_data),
    .i_rx_valid          (rx_valid),
    .i_start             (start),
`ifdef RAM_CTRL_CLEAR_EN
    .i_clear             (clear),
`endif
    .i_tx_ready          (tx_ready),
    .o_tx_data           (tx_data),
    .o_tx_valid          (tx_valid),
    .o_ram_address       (ram_address),
    .o_ram_din           (ram_din),
    .o_ram_write_enabled (ram_we),
    .i_ram_dout          (ram_dout),
    .o_busy              (busy),
    .o_dump_done         (dump_done),
    .o_overrun           (overrun),
    .o_write_pointer     (write_pointer),
    .o_state             (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural RAM: combinational read, clocked write, bench preload port
  assign ram_dout = (ram_address < 6'd40) ? mem[ram_address] : 7'h00;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_we && ram_address < 6'd40) mem[ram_address] <= ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transmit monitor: a transfer is valid&ready, checked mid-cycle
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("tx_extra", 32'(tx_data), 32'hFFFF);
      else chk("tx_char", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (dump_done) begin
      dd_cnt++;
      chk("busy_at_done", 32'(busy), 0);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_mem(input string s, input logic [6:0] fill);
    for (int i = 0; i < 40; i++) begin
      ld_en = 1'b1;
      ld_addr = 6'(i);
      ld_data = (i < s.len()) ? 7'(s[i]) : fill;
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(7'(s[i]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_rx(input logic [6:0] d);
    rx_data = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int s0;
    s0 = dd_cnt;
    for (int i = 0; i < budget && dd_cnt == s0; i++) tick();
    tick();
    tick();
    chk(tag, 32'(dd_cnt - s0), 1);
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(tx_valid), 1);
  endtask

  initial begin
    int bad;
    logic [6:0] d0;

    // reset state
    tick();
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(dump_done), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_wp", 32'(write_pointer), 0);
    chk("rst_state", 32'(state), 0);

    // full string dump with latency check
    load_mem("ECE333 Fall 2015 Digital Systems\n\r", 7'h2E);
    do_reset();
    push_str("ECE333 Fall 2015 Digital Systems\n\r");
    tx_ready = 1'b1;
    pulse_start();
    chk("lat_n1_valid", 32'(tx_valid), 0);
    chk("lat_n1_busy", 32'(busy), 1);
    tick();
    chk("lat_n2_valid", 32'(tx_valid), 1);
    chk("lat_n2_data", 32'(tx_data), 32'h45);
    wait_done("str_done", 200);
    chk("str_busy_after", 32'(busy), 0);

    // receive write, then terminator triggers dump
    do_reset();
    pulse_rx(7'h48);
    chk("wr_idle_we", 32'(ram_we), 0);
    tick();
    chk("wr_we", 32'(ram_we), 1);
    chk("wr_addr", 32'(ram_address), 0);
    chk("wr_din", 32'(ram_din), 32'h48);
    tick();
    chk("wr_wp", 32'(write_pointer), 1);
    chk("wr_we_off", 32'(ram_we), 0);
    exp_q.push_back(7'h48);
    exp_q.push_back(7'h0D);
    pulse_rx(7'h0D);
    wait_done("term_done", 100);
    chk("term_mem1", 32'(mem[1]), 32'h0D);

    // stall mid-dump
    load_mem("abcd\r", 7'h2E);
    do_reset();
    push_str("abcd\r");
    pulse_start();
    tick();
    tick();
    tx_ready = 1'b0;
    wait_valid("stall_valid");
    d0 = tx_data;
    chk("stall_char", 32'(d0), 32'h62);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!tx_valid || tx_data !== d0) bad++;
    end
    chk("stall_hold", 32'(bad), 0);
    tx_ready = 1'b1;
    wait_done("stall_done", 100);

    // single receive during a dump is interleaved without loss
    load_mem("0123456789\r", 7'h2E);
    do_reset();
    push_str("0123456789\r");
    pulse_start();
    tick();
    tick();
    pulse_rx(7'h41);
    wait_done("rx_mid_done", 100);
    chk("rx_mid_mem0", 32'(mem[0]), 32'h41);
    chk("rx_mid_wp", 32'(write_pointer), 1);
    chk("rx_mid_ovr", 32'(overrun), 0);

    // two receives in one SEND wait: second dropped, first lands at address 1 before it is read
    tx_ready = 1'b0;
    push_str("AB23456789\r");
    pulse_start();
    wait_valid("ovr_valid");
    pulse_rx(7'h42);
    pulse_rx(7'h43);
    chk("ovr_flag", 32'(overrun), 1);
    tx_ready = 1'b1;
    wait_done("ovr_done", 100);
    chk("ovr_mem1", 32'(mem[1]), 32'h42);
    chk("ovr_mem2", 32'(mem[2]), 32'h32);
    chk("ovr_wp", 32'(write_pointer), 2);
    chk("ovr_sticky", 32'(overrun), 1);

    // 40 writes wrap the write pointer; dump stops after last address
    do_reset();
    for (int i = 0; i < 40; i++) begin
      pulse_rx(7'h41);
      tick();
      tick();
      tick();
      if (i == 38) chk("wrap_wp39", 32'(write_pointer), 39);
    end
    chk("wrap_wp0", 32'(write_pointer), 0);
    for (int i = 0; i < 40; i++) exp_q.push_back(7'h41);
    pulse_start();
    wait_done("wrap_done", 300);

`ifdef RAM_CTRL_CLEAR_EN
    // bulk clear
    pulse_rx(7'h5A);
    tick();
    tick();
    chk("clr_pre_wp", 32'(write_pointer), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (!(ram_we && ram_address == 6'(i) && ram_din == 7'h20 && busy)) bad++;
      tick();
    end
    chk("clr_cycles", 32'(bad), 0);
    chk("clr_we_off", 32'(ram_we), 0);
    chk("clr_busy_off", 32'(busy), 0);
    chk("clr_wp", 32'(write_pointer), 0);
    for (int i = 0; i < 40; i++) exp_q.push_back(7'h20);
    pulse_start();
    wait_done("clr_dump_done", 300);
`endif

    // asynchronous reset while waiting in SEND
    load_mem("xyz\r", 7'h2E);
    do_reset();
    tx_ready = 1'b0;
    pulse_start();
    wait_valid("arst_valid");
    chk("arst_in_send", 32'(state), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    chk("arst_q_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
